// File: rtl/sar_search_controller_pkg.sv
// Shared encodings and default sizes for the SAR search controller.
// Imported by the controller RTL and by its bench.
package sar_search_controller_pkg;

    localparam int SAR_WIDTH = 4;
    localparam int SAR_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_search_controller.sv
// Successive-approximation search against an external magnitude comparator.
// Resolves one operand bit per cycle, MSB first, stopping early on equality.
module sar_search_controller
    import sar_search_controller_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH,
    parameter int CNT_W = SAR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] n_cmp,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);

    sar_state_t       state;
    sar_state_t       state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mask_n;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // Trial bit is kept when the probe was not above the target.
    always_comb begin
        acc_n  = cmp_gt ? acc : probe;
        mask_n = ONE << (idx - 1'b1);
        last   = cmp_eq || (idx == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_n = ST_TRIAL;
            end
            ST_TRIAL: begin
                busy = 1'b1;
                if (last) state_n = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Probe/accumulator datapath and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe  <= '0;
            acc    <= '0;
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            n_cmp  <= '0;
            err    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                probe <= MSB;
                acc   <= '0;
                idx   <= IDX_TOP;
                cnt   <= '0;
                err   <= 1'b0;
            end
        end else if (state == ST_TRIAL) begin
            cnt <= cnt + 1'b1;
            if (cmp_gt && cmp_eq) err <= 1'b1;
            if (cmp_eq) begin
                result <= probe;
                n_cmp  <= cnt + 1'b1;
            end else if (idx == '0) begin
                result <= acc_n;
                n_cmp  <= cnt + 1'b1;
            end else begin
                acc   <= acc_n;
                probe <= acc_n | mask_n;
                idx   <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller with an inline comparator model.
// A search-level reference model is checked every cycle.
module tb_sar_search_controller;
    import sar_search_controller_pkg::*;

    localparam int W = SAR_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic         cmp_gt;
    logic         cmp_eq;
    logic [W-1:0] probe;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [2:0]   n_cmp;
    logic         err;

    logic [W-1:0] target = '0;
    logic         force_bad = 1'b0;

    int n_checks = 0;
    int n_bad = 0;

    sar_search_controller #(.WIDTH(W), .CNT_W(SAR_CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .n_cmp  (n_cmp),
        .err    (err)
    );

    assign cmp_gt = force_bad | (probe > target);
    assign cmp_eq = force_bad | (probe == target);

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Probe aimed at bit b: target bits above b, then a 1 at b.
    function automatic int prefix_probe(int t, int b);
        return ((t >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    function automatic int expected_ncmp(int t);
        int z = 0;
        if (t == 0) return W;
        while (z < W && ((t >> z) & 1) == 0) z++;
        return W - z;
    endfunction

    // Search-level reference model.
    bit m_active = 0;
    bit m_fin = 0;
    int m_step = 0;
    int m_probe = 0;
    int m_result = 0;
    int m_n = 0;
    bit m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        bit e;
        bit g;
        if (!rst_n) begin
            m_active <= 0;
            m_fin    <= 0;
            m_step   <= 0;
            m_probe  <= 0;
            m_result <= 0;
            m_n      <= 0;
            m_err    <= 0;
        end else if (m_fin) begin
            m_fin <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1;
                m_step   <= 0;
                m_err    <= 0;
                m_probe  <= 1 << (W - 1);
            end
        end else begin
            e = force_bad || (m_probe == int'(target));
            g = force_bad || (m_probe > int'(target));
            if (e && g) m_err <= 1;
            if (e || m_step == W - 1) begin
                m_active <= 0;
                m_fin    <= 1;
                m_result <= e ? m_probe : int'(target);
                m_n      <= m_step + 1;
            end else begin
                m_step  <= m_step + 1;
                m_probe <= prefix_probe(int'(target), W - 2 - m_step);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_active || m_fin));
        chk("done", int'(done), int'(m_fin));
        chk("probe", int'(probe), m_probe);
        chk("result", int'(result), m_result);
        chk("n_cmp", int'(n_cmp), m_n);
        chk("err", int'(err), int'(m_err));
    end

    task automatic search(input logic [W-1:0] t, input logic frc,
                          input int e_res, input int e_n, input int e_err,
                          input logic [15:0] ep, input bit chkp);
        int edges;
        bit got;
        int probes[$];
        target    = t;
        force_bad = frc;
        got       = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            probes.push_back(int'(probe));
            @(posedge clk);
            edges++;
        end
        chk("done_seen", int'(got), 1);
        chk("lit_result", int'(result), e_res);
        chk("lit_n_cmp", int'(n_cmp), e_n);
        chk("lit_err", int'(err), e_err);
        chk("lit_latency", edges, e_n + 1);
        chk("model_result", m_result, e_res);
        chk("model_n", m_n, e_n);
        if (chkp) begin
            chk("n_probes", probes.size(), e_n);
            for (int i = 0; i < probes.size() && i < 4; i++)
                chk("probe_seq", probes[i], int'(ep[15-4*i -: 4]));
        end
        force_bad = 1'b0;
    endtask

    initial begin
        int nd;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        search(4'd5, 1'b0, 5, 4, 0, 16'h8465, 1);
        search(4'd8, 1'b0, 8, 1, 0, 16'h8000, 1);
        search(4'd10, 1'b0, 10, 3, 0, 16'h8CA0, 1);
        search(4'd0, 1'b0, 0, 4, 0, 16'h8421, 1);
        search(4'd15, 1'b0, 15, 4, 0, 16'h8CEF, 1);

        // Start pulse mid-search must be ignored.
        target = 4'd3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("single_done", nd, 1);
        chk("ignored_result", int'(result), 3);

        // Reset in the middle of a search.
        target = 4'd9;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_probe", int'(probe), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        search(4'd9, 1'b0, 9, 4, 0, 16'h8CA9, 1);

        // Start held high runs searches back to back.
        target = 4'd6;
        @(negedge clk);
        start = 1'b1;
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        start = 1'b0;
        chk("b2b_dones", int'(nd >= 2), 1);
        repeat (6) @(negedge clk);

        for (int t = 0; t < 16; t++)
            search(4'(t), 1'b0, t, expected_ncmp(t), 0, 16'h0, 0);

        search(4'd3, 1'b1, 8, 1, 1, 16'h8000, 1);
        search(4'd12, 1'b0, 12, 2, 0, 16'h8C00, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_bad);
        $finish;
    end

endmodule
